// File: rtl/vdic_dut_2023.sv
// vdic_dut_2023: signed 16x16 multiplier with a req/ack handshake, operand
// parity checking and a 16-cycle sequential shift-add datapath.
// Optional feature macro: VDIC_DUT_PARITY_CHECK_EN. When it is defined,
// operand parity is checked and a bad operand skips the multiply and reports
// an error. When it is undefined, parity inputs are ignored and every request
// is multiplied.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req; operands captured on the edge that sees req
// CALC  | 16 shift-add iterations on the operand magnitudes
// DONE  | sign fix, publish result/result_parity/error, pulse result_rdy
module vdic_dut_2023 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] arg_a,
  input  logic        arg_a_parity,
  input  logic [15:0] arg_b,
  input  logic        arg_b_parity,
  input  logic        req,
  output logic        ack,
  output logic [31:0] result,
  output logic        result_parity,
  output logic        result_rdy,
  output logic        arg_parity_error
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [3:0]  cnt;
  logic        neg;
  logic        err;
  logic        par_err_in;
  logic [31:0] signed_res;

`ifdef VDIC_DUT_PARITY_CHECK_EN
  assign par_err_in = ((^arg_a) != arg_a_parity) || ((^arg_b) != arg_b_parity);
`else
  // Parity inputs are deliberately unused in this build.
  logic unused_parity;
  assign unused_parity = arg_a_parity ^ arg_b_parity;
  assign par_err_in    = 1'b0;
`endif

  // Magnitude of a two's complement value; -32768 maps to 16'h8000 (32768).
  function automatic logic [15:0] mag16(input logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  // Sign fix of the unsigned magnitude product.
  assign signed_res = neg ? (~acc + 32'd1) : acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a parity error jumps straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = par_err_in ? DONE : CALC;
      CALC: if (cnt == 4'd0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift-add datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack              <= 1'b0;
      result           <= 32'd0;
      result_parity    <= 1'b0;
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
      acc              <= 32'd0;
      mcand            <= 32'd0;
      mplier           <= 16'd0;
      cnt              <= 4'd0;
      neg              <= 1'b0;
      err              <= 1'b0;
    end else begin
      ack        <= 1'b0;
      result_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            ack    <= 1'b1;
            acc    <= 32'd0;
            mcand  <= {16'd0, mag16(arg_a)};
            mplier <= mag16(arg_b);
            cnt    <= 4'd15;
            neg    <= arg_a[15] ^ arg_b[15];
            err    <= par_err_in;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 4'd1;
        end
        DONE: begin
          result_rdy       <= 1'b1;
          arg_parity_error <= err;
          result           <= err ? 32'd0 : signed_res;
          result_parity    <= err ? 1'b0 : (^signed_res);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vdic_dut_2023.sv
// Scoreboard bench for vdic_dut_2023: the driver pushes the expected response
// (from an arithmetic model) when a request is acknowledged; an independent
// monitor pops and compares whenever result_rdy is seen.
module tb_vdic_dut_2023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] arg_a = 16'd0;
  logic [15:0] arg_b = 16'd0;
  logic        arg_a_parity = 1'b0;
  logic        arg_b_parity = 1'b0;
  logic        req = 1'b0;
  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        result_rdy;
  logic        arg_parity_error;

  typedef struct {
    logic [31:0] res;
    logic        par;
    logic        err;
    int          ack_cyc;
    int          rdy_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          next_free = 0;
  logic [31:0] last_res = 32'd0;
  logic        last_par = 1'b0;
  logic        last_err = 1'b0;
  logic        prev_ack = 1'b0;

  vdic_dut_2023 dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .req              (req),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) begin
    last_res = 32'd0;
    last_par = 1'b0;
    last_err = 1'b0;
    prev_ack = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic par16(input logic [15:0] x);
    return ^x;
  endfunction

  // Reference: plain signed arithmetic, latency taken from the handshake rules.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic pa, input logic pb, input int ack_cyc);
    exp_t e;
    int   ia;
    int   ib;
    bit   bad;
    ia = int'($signed(a));
    ib = int'($signed(b));
`ifdef VDIC_DUT_PARITY_CHECK_EN
    bad = ((^a) !== pa) || ((^b) !== pb);
`else
    bad = 1'b0;
`endif
    e.ack_cyc = ack_cyc;
    if (bad) begin
      e.res = 32'd0; e.par = 1'b0; e.err = 1'b1; e.rdy_cyc = ack_cyc + 1;
    end else begin
      e.res = 32'(ia * ib); e.par = ^e.res; e.err = 1'b0; e.rdy_cyc = ack_cyc + 17;
    end
    return e;
  endfunction

  // Raise req with the given operands (caller is at a negedge or in reset),
  // wait for ack, push the expectation, then scramble operands while busy.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                         input logic pa, input logic pb, input bit hold);
    int   start;
    int   exp_ack;
    bit   got;
    exp_t e;
    arg_a = a; arg_b = b; arg_a_parity = pa; arg_b_parity = pb; req = 1'b1;
    start   = cyc;
    exp_ack = (start + 1 > next_free) ? start + 1 : next_free;
    got     = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    if (!got) begin
      req = 1'b0;
      return;
    end
    check("ack_cycle", 32'(cyc), 32'(exp_ack));
    e = model(a, b, pa, pb, cyc);
    sb.push_back(e);
    next_free = e.rdy_cyc + 1;
    if (!hold) req = 1'b0;
    arg_a = 16'($urandom); arg_b = 16'($urandom);
    arg_a_parity = 1'($urandom); arg_b_parity = 1'($urandom);
  endtask

  // Monitor: pulse shape, ack-while-busy, result checks and hold-between-results.
  initial begin
    exp_t e;
    int   busy;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack) begin
          check("ack_single", 32'(prev_ack), 32'd0);
          busy = 0;
          foreach (sb[i]) if (sb[i].ack_cyc != cyc) busy = 1;
          check("ack_idle", 32'(busy), 32'd0);
        end
        prev_ack = ack;
        if (result_rdy) begin
          if (sb.size() == 0) begin
            check("spurious_rdy", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("result_parity", 32'(result_parity), 32'(e.par));
            check("parity_error", 32'(arg_parity_error), 32'(e.err));
            check("rdy_cycle", 32'(cyc), 32'(e.rdy_cyc));
          end
          last_res = result; last_par = result_parity; last_err = arg_parity_error;
        end else begin
          check("hold_result", result, last_res);
          check("hold_parity", 32'(result_parity), 32'(last_par));
          check("hold_error", 32'(arg_parity_error), 32'(last_err));
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_result_parity", 32'(result_parity), 32'd0);
    check("rst_result_rdy", 32'(result_rdy), 32'd0);
    check("rst_parity_error", 32'(arg_parity_error), 32'd0);
    rst_n = 1'b1;

    run_txn(16'd3,      16'd4,      1'b0, 1'b1, 1'b0);
    run_txn(16'hFFFF,   16'd1,      1'b0, 1'b1, 1'b0);
    run_txn(16'h8000,   16'h8000,   1'b1, 1'b1, 1'b0);
    run_txn(16'h8000,   16'h7FFF,   1'b1, par16(16'h7FFF), 1'b0);
    run_txn(16'h1234,   16'd0,      par16(16'h1234), 1'b0, 1'b0);
    run_txn(16'd5,      16'd2,      1'b1, 1'b1, 1'b0);
    run_txn(16'd100,    16'hFFF9,   par16(16'd100), par16(16'hFFF9), 1'b1);
    run_txn(16'hFED4,   16'd45,     par16(16'hFED4), par16(16'd45), 1'b1);
    run_txn(16'd6,      16'd6,      1'b1, 1'b0, 1'b1);
    run_txn(16'd77,     16'd77,     par16(16'd77), par16(16'd77), 1'b0);

    run_txn(16'd7, 16'd9, par16(16'd7), par16(16'd9), 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    next_free = 0;
    #1;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_result_parity", 32'(result_parity), 32'd0);
    check("abort_result_rdy", 32'(result_rdy), 32'd0);
    check("abort_parity_error", 32'(arg_parity_error), 32'd0);
    fork
      run_txn(16'd2, 16'hFFFD, par16(16'd2), par16(16'hFFFD), 1'b0);
      begin #1 rst_n = 1'b1; end
    join

    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_txn(ra, rb,
              ($urandom_range(3) == 0) ? ~par16(ra) : par16(ra),
              ($urandom_range(3) == 0) ? ~par16(rb) : par16(rb),
              1'($urandom));
    end
    req = 1'b0;

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vdic_dut_2023.md
VDIC_DUT_2023 -- requirements
Module: vdic_dut_2023

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; port names follow the codebase (clk, rst_n).
REQ-003 SHALL provide these ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arg_a  in  16  signed (two's complement) operand A.
- arg_a_parity  in  1  even-parity bit of arg_a.
- arg_b  in  16  signed operand B.
- arg_b_parity  in  1  even-parity bit of arg_b.
- req  in  1  request; held high by the requester until ack.
- ack  out  1  one-cycle pulse: operands captured.
- result  out  32  signed product A*B, or 0 on parity error.
- result_parity  out  1  even parity of result (XOR of all result bits).
- result_rdy  out  1  one-cycle pulse: result, result_parity and arg_parity_error are valid.
- arg_parity_error  out  1  a captured operand failed its parity check.

Function
REQ-004 SHALL implement states IDLE, CALC, DONE.
REQ-005 In IDLE, when a rising edge E0 samples req=1, the block SHALL register arg_a, arg_b and both parity bits, drive ack=1 for exactly the cycle after E0, and leave IDLE.
REQ-006 Operand parity SHALL be OK when ^arg_x == arg_x_parity; any mismatch flags an error.
REQ-007 With no parity error, the block SHALL compute the product by sequential shift-add over 16 cycles: magnitude multiply, then sign fix from arg_a[15]^arg_b[15].
REQ-008 On the no-error path, result_rdy SHALL be 1 for exactly one cycle, 17 edges after E0, with result=A*B (full 32-bit, no overflow possible) and arg_parity_error=0.
REQ-009 On a parity error, the block SHALL skip CALC; after edge E0+1, result_rdy=1 for one cycle, result=0, result_parity=0, arg_parity_error=1.
REQ-010 result, result_parity and arg_parity_error SHALL hold their values until the next result_rdy pulse or reset.
REQ-011 req and operand changes SHALL be ignored outside IDLE; ack SHALL never assert while busy.
REQ-012 After DONE, the block SHALL return to IDLE. If req is still high, the block SHALL start a new transaction on the next edge, whose ack comes at the earliest one cycle after the result_rdy pulse.
REQ-013 Boundary cases: -32768*-32768 SHALL give 0x40000000, -32768*32767 SHALL give 0xC0008000, and x*0 SHALL give 0.

Reset
REQ-014 rst_n=0 SHALL immediately, asynchronously force: state=IDLE, ack=0, result=0, result_parity=0, result_rdy=0, arg_parity_error=0, internal registers=0.
REQ-015 Reset asserted mid-transaction SHALL abort it; no result_rdy SHALL be produced for the aborted operands.
REQ-016 The first req SHALL be sampled on the first rising edge after rst_n deasserts.

Configuration
REQ-017 Macro VDIC_DUT_PARITY_CHECK_EN: when defined, parity checking and the error path SHALL behave per REQ-006/REQ-009.
REQ-018 When VDIC_DUT_PARITY_CHECK_EN is undefined, parity inputs SHALL be ignored, arg_parity_error SHALL be constant 0, and every request SHALL take the multiply path; result_parity SHALL still be generated.

Verification
REQ-019 A=3 (par 0), B=4 (par 1) -> ack one cycle after E0; result_rdy at E0+17; result=0x0000000C, result_parity=0, arg_parity_error=0.
REQ-020 A=-1 (0xFFFF, par 0), B=1 (par 1) -> result=0xFFFFFFFF, result_parity=0.
REQ-021 A=0x8000 (par 1), B=0x8000 (par 1) -> result=0x40000000, result_parity=1.
REQ-022 A=5 with arg_a_parity=1 (wrong), B=2 -> result_rdy at E0+1, result=0, arg_parity_error=1; with the macro undefined -> result=0x0000000A, arg_parity_error=0.
REQ-023 Start A=7, B=9, pulse rst_n low at E0+8 -> all outputs 0 immediately, no result_rdy; the next request A=2, B=-3 -> result=0xFFFFFFFA.
REQ-024 Hold req high across two transactions with operands changed while busy -> each result matches the operands captured at its own ack.
